// File: rtl/stove_timer_ctrl.sv
// rtl/stove_timer_ctrl.sv - stove cook-timer controller driving an external time register
module stove_timer_ctrl #(
    parameter int WIDTH          = 8,
    parameter int MAX_TIME       = 99,
    parameter int PRESET         = 30,
    parameter int BUZZ_TICKS     = 5,
    parameter int REG_CTRL_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      async_reset,
    input  logic                      btn_up,
    input  logic                      btn_down,
    input  logic                      btn_start,
    input  logic                      btn_stop,
    input  logic                      btn_preset,
    input  logic                      tick,
    input  logic [WIDTH-1:0]          time_val,
    output logic [REG_CTRL_WIDTH-1:0] reg_ctrl,
    output logic [WIDTH-1:0]          reg_data,
    output logic                      heater_on,
    output logic                      buzzer,
    output logic                      busy
);

    // Register command encodings shared with the time register block
    localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_NOP = REG_CTRL_WIDTH'(0);
    localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_LD  = REG_CTRL_WIDTH'(1);
    localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_CLR = REG_CTRL_WIDTH'(2);
    localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_INC = REG_CTRL_WIDTH'(3);
    localparam logic [REG_CTRL_WIDTH-1:0] REG_CTRL_DEC = REG_CTRL_WIDTH'(4);

    localparam int              CNT_W     = $clog2(BUZZ_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BUZZ_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUZZ_TICKS - 1);
    localparam logic [WIDTH-1:0] MAX_V    = WIDTH'(MAX_TIME);
    localparam logic [WIDTH-1:0] ONE_V    = WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                      state;
    logic [CNT_W-1:0]            buzz_cnt;
    logic                        can_inc;
    logic                        can_dec;
    logic                        up_only;
    logic                        down_only;
    logic                        any_btn;
    logic [REG_CTRL_WIDTH-1:0]   updown_cmd;

    // Wrap guards and the up/down cancellation shared by IDLE and PAUSE
    always_comb begin
        can_inc    = (time_val < MAX_V);
        can_dec    = (time_val != '0);
        up_only    = btn_up && !btn_down;
        down_only  = btn_down && !btn_up;
        any_btn    = btn_up | btn_down | btn_start | btn_stop | btn_preset;
        updown_cmd = REG_CTRL_NOP;
        if (up_only && can_inc) begin
            updown_cmd = REG_CTRL_INC;
        end else if (down_only && can_dec) begin
            updown_cmd = REG_CTRL_DEC;
        end
    end

    assign reg_data = WIDTH'(PRESET);

    // Mealy register command: highest-priority active input of the current state wins
    always_comb begin
        reg_ctrl = REG_CTRL_NOP;
        case (state)
            IDLE: begin
                if (btn_stop) begin
                    reg_ctrl = REG_CTRL_CLR;
                end else if (!btn_start) begin
                    if (btn_preset) begin
                        reg_ctrl = REG_CTRL_LD;
                    end else begin
                        reg_ctrl = updown_cmd;
                    end
                end
            end
            RUN: begin
                if (!btn_stop) begin
                    if (tick) begin
                        if (can_dec) begin
                            reg_ctrl = REG_CTRL_DEC;
                        end
                    end else if (up_only && can_inc) begin
                        reg_ctrl = REG_CTRL_INC;
                    end
                end
            end
            PAUSE: begin
                if (btn_stop) begin
                    reg_ctrl = REG_CTRL_CLR;
                end else if (!btn_start) begin
                    reg_ctrl = updown_cmd;
                end
            end
            default: reg_ctrl = REG_CTRL_NOP;
        endcase
    end

    // Cook-timer FSM with registered heater, buzzer and busy outputs
    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            state     <= IDLE;
            heater_on <= 1'b0;
            buzzer    <= 1'b0;
            busy      <= 1'b0;
            buzz_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!btn_stop && btn_start && can_dec) begin
                        state     <= RUN;
                        heater_on <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (btn_stop) begin
                        state     <= PAUSE;
                        heater_on <= 1'b0;
                    end else if (tick && (time_val <= ONE_V)) begin
                        // Last second counted down (or an already-empty timer)
                        state     <= DONE;
                        heater_on <= 1'b0;
                        busy      <= 1'b0;
                        buzzer    <= 1'b1;
                        buzz_cnt  <= '0;
                    end
                end
                PAUSE: begin
                    if (btn_stop) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (btn_start) begin
                        state     <= RUN;
                        heater_on <= 1'b1;
                    end
                end
                DONE: begin
                    if (any_btn) begin
                        state  <= IDLE;
                        buzzer <= 1'b0;
                    end else if (tick) begin
                        if (buzz_cnt >= CNT_LAST) begin
                            state  <= IDLE;
                            buzzer <= 1'b0;
                        end
                        if (buzz_cnt != CNT_MAX) begin
                            buzz_cnt <= buzz_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stove_timer_ctrl.sv
// tb/tb_stove_timer_ctrl.sv - self-checking bench for stove_timer_ctrl
module tb_stove_timer_ctrl;

    localparam int MAXT = 99;
    localparam int PRE  = 30;
    localparam int BT   = 5;

    localparam logic [2:0] C_NOP = 3'd0;
    localparam logic [2:0] C_LD  = 3'd1;
    localparam logic [2:0] C_CLR = 3'd2;
    localparam logic [2:0] C_INC = 3'd3;
    localparam logic [2:0] C_DEC = 3'd4;

    // Button vector bits: {preset, stop, start, down, up, tick}
    localparam logic [5:0] TK = 6'b000001;
    localparam logic [5:0] UP = 6'b000010;
    localparam logic [5:0] DN = 6'b000100;
    localparam logic [5:0] ST = 6'b001000;
    localparam logic [5:0] SP = 6'b010000;
    localparam logic [5:0] PR = 6'b100000;
    localparam logic [5:0] NO = 6'b000000;

    logic       clk = 1'b0;
    logic       async_reset = 1'b1;
    logic       btn_up = 1'b0, btn_down = 1'b0, btn_start = 1'b0;
    logic       btn_stop = 1'b0, btn_preset = 1'b0, tick = 1'b0;
    logic [7:0] time_val;
    logic [2:0] reg_ctrl;
    logic [7:0] reg_data;
    logic       heater_on, buzzer, busy;

    stove_timer_ctrl dut (
        .clk(clk), .async_reset(async_reset),
        .btn_up(btn_up), .btn_down(btn_down), .btn_start(btn_start),
        .btn_stop(btn_stop), .btn_preset(btn_preset), .tick(tick),
        .time_val(time_val), .reg_ctrl(reg_ctrl), .reg_data(reg_data),
        .heater_on(heater_on), .buzzer(buzzer), .busy(busy)
    );

    always #5 clk = ~clk;

    // Time register the controller talks to; pre_en lets the bench plant a value
    logic       pre_en = 1'b0;
    logic [7:0] pre_v  = 8'd0;
    logic [7:0] treg   = 8'd0;
    always @(posedge clk) begin
        if (pre_en) treg <= pre_v;
        else case (reg_ctrl)
            C_LD:    treg <= reg_data;
            C_CLR:   treg <= 8'd0;
            C_INC:   treg <= treg + 8'd1;
            C_DEC:   treg <= treg - 8'd1;
            default: treg <= treg;
        endcase
    end
    assign time_val = treg;

    // Reference model
    typedef enum {M_IDLE, M_RUN, M_PAUSE, M_DONE} mst_t;
    mst_t ms;
    int   mt;
    bit   mh, mb, mz;
    int   mcnt;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [5:0] b;
        logic       pe;
        logic [7:0] pv;
        logic [2:0] cmd;
        logic       heat, bsy, bz;
        logic [7:0] tv;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mreset();
        ms = M_IDLE; mh = 0; mb = 0; mz = 0; mcnt = 0;
    endtask

    function automatic logic [2:0] updown(input bit up, input bit dn);
        if (up && !dn && mt < MAXT) return C_INC;
        if (dn && !up && mt > 0) return C_DEC;
        return C_NOP;
    endfunction

    task automatic model_cycle(input logic [5:0] b, output logic [2:0] cmd);
        bit tk = b[0], up = b[1], dn = b[2], st = b[3], sp = b[4], pr = b[5];
        cmd = C_NOP;
        case (ms)
            M_IDLE: begin
                if (sp) cmd = C_CLR;
                else if (st) begin
                    if (mt != 0) begin ms = M_RUN; mh = 1; mb = 1; end
                end
                else if (pr) cmd = C_LD;
                else cmd = updown(up, dn);
            end
            M_RUN: begin
                if (sp) begin ms = M_PAUSE; mh = 0; end
                else if (tk) begin
                    if (mt > 0) cmd = C_DEC;
                    if (mt <= 1) begin ms = M_DONE; mh = 0; mb = 0; mz = 1; mcnt = 0; end
                end
                else if (up && !dn && mt < MAXT) cmd = C_INC;
            end
            M_PAUSE: begin
                if (sp) begin cmd = C_CLR; ms = M_IDLE; mb = 0; end
                else if (st) begin ms = M_RUN; mh = 1; end
                else cmd = updown(up, dn);
            end
            M_DONE: begin
                if (up || dn || st || sp || pr) begin mz = 0; ms = M_IDLE; end
                else if (tk) begin
                    mcnt++;
                    if (mcnt >= BT) begin mz = 0; ms = M_IDLE; end
                end
            end
            default: ms = M_IDLE;
        endcase
        case (cmd)
            C_LD:    mt = PRE;
            C_CLR:   mt = 0;
            C_INC:   mt = mt + 1;
            C_DEC:   mt = mt - 1;
            default: mt = mt;
        endcase
    endtask

    // One clock cycle: drive at negedge, compare against the model, advance the model
    task automatic step(input logic [5:0] b, input logic pe, input logic [7:0] pv);
        logic [2:0] ec;
        @(negedge clk);
        {btn_preset, btn_stop, btn_start, btn_down, btn_up, tick} = b;
        pre_en = pe;
        pre_v  = pv;
        #1;
        chk("heater_on", heater_on, mh);
        chk("busy", busy, mb);
        chk("buzzer", buzzer, mz);
        chk("time_val", time_val, mt);
        chk("reg_data", reg_data, PRE);
        model_cycle(b, ec);
        chk("reg_ctrl", reg_ctrl, ec);
        if (pe) mt = pv;
    endtask

    // Reset asserted mid-cycle after the pending edge has been taken
    task automatic do_reset();
        @(posedge clk);
        #2;
        {btn_preset, btn_stop, btn_start, btn_down, btn_up, tick} = 6'b0;
        pre_en = 1'b0;
        async_reset = 1'b1;
        #1;
        chk("rst_heater", heater_on, 0);
        chk("rst_busy", busy, 0);
        chk("rst_buzzer", buzzer, 0);
        chk("rst_reg_ctrl", reg_ctrl, C_NOP);
        mreset();
        @(negedge clk);
        async_reset = 1'b0;
    endtask

    function automatic void add(input logic [5:0] b, input logic pe, input logic [7:0] pv,
                                input logic [2:0] cmd, input logic heat, input logic bsy,
                                input logic bz, input logic [7:0] tv);
        vec_t v;
        v.b = b; v.pe = pe; v.pv = pv; v.cmd = cmd;
        v.heat = heat; v.bsy = bsy; v.bz = bz; v.tv = tv;
        tbl.push_back(v);
    endfunction

    task automatic run_tbl(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].b, tbl[i].pe, tbl[i].pv);
            chk($sformatf("%s[%0d].cmd", tag, i), reg_ctrl, tbl[i].cmd);
            chk($sformatf("%s[%0d].heat", tag, i), heater_on, tbl[i].heat);
            chk($sformatf("%s[%0d].busy", tag, i), busy, tbl[i].bsy);
            chk($sformatf("%s[%0d].buzz", tag, i), buzzer, tbl[i].bz);
            chk($sformatf("%s[%0d].tv", tag, i), time_val, tbl[i].tv);
        end
        tbl.delete();
    endtask

    initial begin
        logic [5:0] b;
        logic       pe;
        logic [7:0] pv;
        mreset();
        mt = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        async_reset = 1'b0;
        step(NO, 0, 0);

        // Up/down stepping, preset + full countdown, buzzer, guards, pause/stop
        for (int i = 0; i < 3; i++) add(UP, 0, 0, C_INC, 0, 0, 0, 8'(i));
        for (int i = 0; i < 3; i++) add(DN, 0, 0, C_DEC, 0, 0, 0, 8'(3 - i));
        add(DN, 0, 0, C_NOP, 0, 0, 0, 0);
        add(PR, 0, 0, C_LD, 0, 0, 0, 0);
        add(ST, 0, 0, C_NOP, 0, 0, 0, 30);
        for (int k = 0; k < 30; k++) add(TK, 0, 0, C_DEC, 1, 1, 0, 8'(30 - k));
        for (int j = 0; j < 5; j++) add(TK, 0, 0, C_NOP, 0, 0, 1, 0);
        add(NO, 0, 0, C_NOP, 0, 0, 0, 0);
        add(NO, 1, 99, C_NOP, 0, 0, 0, 0);
        add(UP, 0, 0, C_NOP, 0, 0, 0, 99);
        add(NO, 0, 0, C_NOP, 0, 0, 0, 99);
        add(NO, 1, 10, C_NOP, 0, 0, 0, 99);
        add(UP | DN, 0, 0, C_NOP, 0, 0, 0, 10);
        add(NO, 0, 0, C_NOP, 0, 0, 0, 10);
        add(NO, 1, 7, C_NOP, 0, 0, 0, 10);
        add(ST, 0, 0, C_NOP, 0, 0, 0, 7);
        add(SP | TK, 0, 0, C_NOP, 1, 1, 0, 7);
        add(NO, 0, 0, C_NOP, 0, 1, 0, 7);
        add(SP, 0, 0, C_CLR, 0, 1, 0, 7);
        add(NO, 0, 0, C_NOP, 0, 0, 0, 0);
        add(ST, 0, 0, C_NOP, 0, 0, 0, 0);
        add(NO, 0, 0, C_NOP, 0, 0, 0, 0);
        run_tbl("plan");

        // Reset while heating
        step(NO, 1, 5);
        step(ST, 0, 0);
        step(NO, 0, 0);
        chk("pre_reset_heater", heater_on, 1);
        do_reset();
        step(NO, 0, 0);
        step(TK, 0, 0);
        step(NO, 0, 0);
        chk("idle_after_reset_tv", time_val, 5);

        // Tick beats up in RUN, then a button ends DONE early
        add(NO, 1, 2, C_NOP, 0, 0, 0, 5);
        add(ST, 0, 0, C_NOP, 0, 0, 0, 2);
        add(TK | UP, 0, 0, C_DEC, 1, 1, 0, 2);
        add(NO, 0, 0, C_NOP, 1, 1, 0, 1);
        add(TK, 0, 0, C_DEC, 1, 1, 0, 1);
        add(NO, 0, 0, C_NOP, 0, 0, 1, 0);
        add(DN, 0, 0, C_NOP, 0, 0, 1, 0);
        add(NO, 0, 0, C_NOP, 0, 0, 0, 0);
        run_tbl("edge");

        // Randomised traffic against the model
        for (int n = 0; n < 4000; n++) begin
            b = 6'b0;
            b[0] = ($urandom_range(0, 3) == 0);
            for (int k = 1; k < 6; k++) b[k] = ($urandom_range(0, 11) == 0);
            pe = ($urandom_range(0, 49) == 0);
            pv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(95, 99))
                                             : 8'($urandom_range(0, 99));
            step(b, pe, pv);
            if ($urandom_range(0, 599) == 0) do_reset();
        end
        step(NO, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
